// File: rtl/phasemeter_lock_sequencer.sv
// Acquisition/lock sequencer: coarse NCO sweep scored by magnitude, load best, track.
// Optional MAG_AVG_EN: 4-sample mean for sweep scoring and the loss test.
module phasemeter_lock_sequencer #(
   parameter int                     ACCUM_WIDTH    = 32,
   parameter int                     MAG_WIDTH      = 14,
   parameter logic [ACCUM_WIDTH-1:0] F_START        = ACCUM_WIDTH'(340161410),
   parameter logic [ACCUM_WIDTH-1:0] F_STEP         = ACCUM_WIDTH'(1048576),
   parameter int                     N_STEPS        = 64,
   parameter int                     SETTLE_SAMPLES = 8,
   parameter int                     MAG_THRESH     = 2000,
   parameter int                     LOSS_COUNT     = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [MAG_WIDTH-1:0]   mag_tdata,
   input  logic                   mag_tvalid,
   output logic [ACCUM_WIDTH-1:0] freq_tdata,
   output logic                   freq_tvalid,
   output logic                   pi_hold,
   output logic                   locked,
   output logic [2:0]             state,
   output logic [15:0]            relock_cnt
);

   localparam int IDX_W  = $clog2(N_STEPS);
   localparam int CNT_W  = $clog2(SETTLE_SAMPLES + 1);
   localparam int LOSS_W = $clog2(LOSS_COUNT + 1);

   localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(N_STEPS - 1);
   localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(SETTLE_SAMPLES - 1);
   localparam logic [LOSS_W-1:0]    LOSS_LAST = LOSS_W'(LOSS_COUNT - 1);
   localparam logic [MAG_WIDTH-1:0] THR       = MAG_WIDTH'(MAG_THRESH);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_TUNE    = 3'd1,
      S_SETTLE  = 3'd2,
      S_MEASURE = 3'd3,
      S_EVAL    = 3'd4,
      S_LOAD    = 3'd5,
      S_TRACK   = 3'd6
   } state_t;

   state_t                 state_q, state_d;
   logic [ACCUM_WIDTH-1:0] freq_q, freq_d;
   logic [ACCUM_WIDTH-1:0] acc_q, acc_d;
   logic [ACCUM_WIDTH-1:0] best_freq_q, best_freq_d;
   logic [MAG_WIDTH-1:0]   best_mag_q, best_mag_d;
   logic                   fvalid_q, fvalid_d;
   logic                   hold_q, hold_d;
   logic                   locked_q, locked_d;
   logic [15:0]            relock_q, relock_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [LOSS_W-1:0]      loss_q, loss_d;

   logic                   smp_v;
   logic [MAG_WIDTH-1:0]   smp_m;
   logic                   settled;
   logic                   scoring;

   assign scoring = (state_q == S_MEASURE) || (state_q == S_TRACK);
   assign settled = mag_tvalid && (cnt_q == CNT_LAST);

`ifdef MAG_AVG_EN
   logic [MAG_WIDTH+1:0] sum_q, sum_d, sum_all;
   logic [1:0]           acnt_q, acnt_d;

   assign sum_all = sum_q + (MAG_WIDTH+2)'(mag_tdata);

   // A block only scores on its 4th strobe; partial sums die on state exit.
   always_comb begin
      sum_d  = sum_q;
      acnt_d = acnt_q;
      smp_v  = mag_tvalid && (acnt_q == 2'd3);
      smp_m  = sum_all[MAG_WIDTH+1:2];
      if (!scoring || !en) begin
         sum_d  = '0;
         acnt_d = '0;
      end else if (mag_tvalid) begin
         if (acnt_q == 2'd3) begin
            sum_d  = '0;
            acnt_d = '0;
         end else begin
            sum_d  = sum_all;
            acnt_d = acnt_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q  <= '0;
         acnt_q <= '0;
      end else begin
         sum_q  <= sum_d;
         acnt_q <= acnt_d;
      end
   end
`else
   always_comb begin
      smp_v = mag_tvalid;
      smp_m = mag_tdata;
   end
`endif

   always_comb begin
      state_d     = state_q;
      freq_d      = freq_q;
      acc_d       = acc_q;
      best_freq_d = best_freq_q;
      best_mag_d  = best_mag_q;
      fvalid_d    = 1'b0;
      hold_d      = hold_q;
      locked_d    = locked_q;
      relock_d    = relock_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      loss_d      = loss_q;
      if (!en) begin
         state_d  = S_IDLE;
         hold_d   = 1'b1;
         locked_d = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d    = S_TUNE;
               idx_d      = '0;
               best_mag_d = '0;
               acc_d      = F_START;
               if (relock_q != 16'hFFFF) relock_d = relock_q + 16'd1;
            end
            S_TUNE: begin
               freq_d   = acc_q;
               fvalid_d = 1'b1;
               cnt_d    = '0;
               state_d  = S_SETTLE;
            end
            S_SETTLE: begin
               if (settled) begin
                  cnt_d   = '0;
                  state_d = S_MEASURE;
               end else if (mag_tvalid) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_MEASURE: begin
               if (smp_v) begin
                  if (smp_m > best_mag_q) begin
                     best_mag_d  = smp_m;
                     best_freq_d = freq_q;
                  end
                  if (idx_q == IDX_LAST) begin
                     state_d = S_EVAL;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                     acc_d   = acc_q + F_STEP;
                     state_d = S_TUNE;
                  end
               end
            end
            S_EVAL: begin
               if (best_mag_q >= THR) begin
                  freq_d   = best_freq_q;
                  fvalid_d = 1'b1;
                  cnt_d    = '0;
                  state_d  = S_LOAD;
               end else begin
                  idx_d      = '0;
                  best_mag_d = '0;
                  acc_d      = F_START;
                  state_d    = S_TUNE;
               end
            end
            S_LOAD: begin
               if (settled) begin
                  cnt_d    = '0;
                  loss_d   = '0;
                  hold_d   = 1'b0;
                  locked_d = 1'b1;
                  state_d  = S_TRACK;
               end else if (mag_tvalid) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_TRACK: begin
               if (smp_v) begin
                  if (smp_m >= THR) begin
                     loss_d = '0;
                  end else if (loss_q == LOSS_LAST) begin
                     loss_d     = '0;
                     hold_d     = 1'b1;
                     locked_d   = 1'b0;
                     idx_d      = '0;
                     best_mag_d = '0;
                     acc_d      = F_START;
                     state_d    = S_TUNE;
                     if (relock_q != 16'hFFFF) relock_d = relock_q + 16'd1;
                  end else begin
                     loss_d = loss_q + 1'b1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         freq_q      <= F_START;
         acc_q       <= F_START;
         best_freq_q <= F_START;
         best_mag_q  <= '0;
         fvalid_q    <= 1'b0;
         hold_q      <= 1'b1;
         locked_q    <= 1'b0;
         relock_q    <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         loss_q      <= '0;
      end else begin
         state_q     <= state_d;
         freq_q      <= freq_d;
         acc_q       <= acc_d;
         best_freq_q <= best_freq_d;
         best_mag_q  <= best_mag_d;
         fvalid_q    <= fvalid_d;
         hold_q      <= hold_d;
         locked_q    <= locked_d;
         relock_q    <= relock_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         loss_q      <= loss_d;
      end
   end

   assign freq_tdata  = freq_q;
   assign freq_tvalid = fvalid_q;
   assign pi_hold     = hold_q;
   assign locked      = locked_q;
   assign state       = state_q;
   assign relock_cnt  = relock_q;

endmodule

// File: tb/tb_phasemeter_lock_sequencer.sv
// Directed bench for phasemeter_lock_sequencer: sweep, no-carrier, tie, loss,
// abort, async reset and word wrap, with hand-computed expectations.
module tb_phasemeter_lock_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en = 1'b0;
   logic        en2 = 1'b0;
   logic [13:0] mag_tdata = '0;
   logic        mag_tvalid = 1'b0;

   logic [31:0] freq_tdata, freq2;
   logic        freq_tvalid, fvalid2;
   logic        pi_hold, hold2;
   logic        locked, locked2;
   logic [2:0]  state, state2;
   logic [15:0] relock_cnt, relock2;

   int npass = 0;
   int ntotal = 0;
   logic [31:0] fq[$];

   always #5 clk = ~clk;

   phasemeter_lock_sequencer #(
      .ACCUM_WIDTH(32), .MAG_WIDTH(14),
      .F_START(32'd1000), .F_STEP(32'd100),
      .N_STEPS(4), .SETTLE_SAMPLES(2),
      .MAG_THRESH(500), .LOSS_COUNT(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .mag_tdata(mag_tdata), .mag_tvalid(mag_tvalid),
      .freq_tdata(freq_tdata), .freq_tvalid(freq_tvalid),
      .pi_hold(pi_hold), .locked(locked),
      .state(state), .relock_cnt(relock_cnt)
   );

   phasemeter_lock_sequencer #(
      .ACCUM_WIDTH(32), .MAG_WIDTH(14),
      .F_START(32'hFFFFFF00), .F_STEP(32'h100),
      .N_STEPS(4), .SETTLE_SAMPLES(2),
      .MAG_THRESH(500), .LOSS_COUNT(3)
   ) dut_wrap (
      .clk(clk), .rst_n(rst_n), .en(en2),
      .mag_tdata(mag_tdata), .mag_tvalid(mag_tvalid),
      .freq_tdata(freq2), .freq_tvalid(fvalid2),
      .pi_hold(hold2), .locked(locked2),
      .state(state2), .relock_cnt(relock2)
   );

   always @(posedge clk)
      if (freq_tvalid) fq.push_back(freq_tdata);

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [13:0] m);
      repeat (15) tick();
      mag_tdata  = m;
      mag_tvalid = 1'b1;
      tick();
      mag_tvalid = 1'b0;
   endtask

   // two settle strobes then the scored one
   task automatic step(input logic [13:0] m);
      send(14'd0);
      send(14'd0);
      send(m);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #2;
      check("rst_state", 32'(state), 32'd0);
      check("rst_freq", freq_tdata, 32'd1000);
      check("rst_fvalid", 32'(freq_tvalid), 32'd0);
      check("rst_hold", 32'(pi_hold), 32'd1);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_relock", 32'(relock_cnt), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // sweep 100,900,300,200 -> load 1100
      en = 1'b1;
      tick();
      check("sw_tune", 32'(state), 32'd1);
      check("sw_relock", 32'(relock_cnt), 32'd1);
      tick();
      check("sw_f0", freq_tdata, 32'd1000);
      check("sw_fv0", 32'(freq_tvalid), 32'd1);
      tick();
      check("sw_fv0_one", 32'(freq_tvalid), 32'd0);
      step(14'd100);
      step(14'd900);
      step(14'd300);
      step(14'd200);
      check("sw_eval", 32'(state), 32'd4);
      tick();
      check("sw_load", 32'(state), 32'd5);
      check("sw_loadf", freq_tdata, 32'd1100);
      send(14'd0);
      check("sw_notyet", 32'(locked), 32'd0);
      send(14'd0);
      check("sw_track", 32'(state), 32'd6);
      check("sw_locked", 32'(locked), 32'd1);
      check("sw_hold", 32'(pi_hold), 32'd0);
      check("sw_relock1", 32'(relock_cnt), 32'd1);
      check("sw_nwords", fq.size(), 32'd5);
      check("sw_w0", fq[0], 32'd1000);
      check("sw_w1", fq[1], 32'd1100);
      check("sw_w2", fq[2], 32'd1200);
      check("sw_w3", fq[3], 32'd1300);
      check("sw_w4", fq[4], 32'd1100);

      // loss of lock
      send(14'd400);
      send(14'd400);
      send(14'd600);
      check("ls_held600", 32'(locked), 32'd1);
      send(14'd400);
      send(14'd400);
      check("ls_held2", 32'(locked), 32'd1);
      check("ls_freq_keep", freq_tdata, 32'd1100);
      send(14'd400);
      check("ls_state", 32'(state), 32'd1);
      check("ls_locked", 32'(locked), 32'd0);
      check("ls_hold", 32'(pi_hold), 32'd1);
      check("ls_relock", 32'(relock_cnt), 32'd2);
      tick();
      check("ls_freq", freq_tdata, 32'd1000);
      check("ls_fv", 32'(freq_tvalid), 32'd1);

      // abort mid-settle
      send(14'd0);
      check("ab_settle", 32'(state), 32'd2);
      en = 1'b0;
      tick();
      check("ab_idle", 32'(state), 32'd0);
      check("ab_hold", 32'(pi_hold), 32'd1);
      check("ab_freq", freq_tdata, 32'd1000);
      check("ab_fv", 32'(freq_tvalid), 32'd0);

      // no carrier: second pass restarts at 1000
      fq.delete();
      en = 1'b1;
      tick();
      check("nc_relock", 32'(relock_cnt), 32'd3);
      tick();
      step(14'd100);
      step(14'd100);
      step(14'd100);
      step(14'd100);
      tick();
      check("nc_retune", 32'(state), 32'd1);
      tick();
      check("nc_settle", 32'(state), 32'd2);
      check("nc_freq", freq_tdata, 32'd1000);
      check("nc_locked", 32'(locked), 32'd0);
      check("nc_relock2", 32'(relock_cnt), 32'd3);
      tick();
      check("nc_nwords", fq.size(), 32'd5);
      check("nc_w3", fq[3], 32'd1300);
      check("nc_w4", fq[4], 32'd1000);

      // tie keeps earlier step
      step(14'd700);
      step(14'd700);
      step(14'd0);
      step(14'd0);
      tick();
      check("tie_load", 32'(state), 32'd5);
      check("tie_freq", freq_tdata, 32'd1000);
      check("tie_fv", 32'(freq_tvalid), 32'd1);
      send(14'd0);
      send(14'd0);
      check("tie_locked", 32'(locked), 32'd1);

      // async reset mid-track, no clock edge
      #2 rst_n = 1'b0;
      en = 1'b0;
      #1;
      check("ar_state", 32'(state), 32'd0);
      check("ar_locked", 32'(locked), 32'd0);
      check("ar_hold", 32'(pi_hold), 32'd1);
      check("ar_relock", 32'(relock_cnt), 32'd0);
      check("ar_freq", freq_tdata, 32'd1000);
      tick();
      rst_n = 1'b1;
      tick();

      // accumulator wraps modulo 2^32
      en2 = 1'b1;
      tick();
      tick();
      check("wr_f0", freq2, 32'hFFFFFF00);
      step(14'd0);
      tick();
      check("wr_f1", freq2, 32'h00000000);
      check("wr_fv", 32'(fvalid2), 32'd1);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
